// File: rtl/regfile_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_sb_if : decode-stage register file / scoreboard bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] i1;
  logic [XLEN-1:0] rdata2;
  logic            RegWrite;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] rwdata;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            stall;
  logic [AW:0]     pend_cnt;

  modport master (
    output rs1, rs2, RegWrite, rd, rwdata, issue_en, issue_rd,
    input  i1, rdata2, rs1_busy, rs2_busy, stall, pend_cnt
  );

  modport slave (
    input  rs1, rs2, RegWrite, rd, rwdata, issue_en, issue_rd,
    output i1, rdata2, rs1_busy, rs2_busy, stall, pend_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb : 2R/1W register file with write bypass and pending scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  regfile_sb_if.slave   bus
);
  localparam int NREGS = 2**AW;
  localparam bit c_byp = (BYPASS != 0);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_pend_cnt;

  logic w_wr, w_fwd1, w_fwd2, w_fwd_iss;
  logic w_busy1, w_busy2, w_waw, w_stall;
  logic w_set, w_same, w_inc, w_dec;

  // Writes are masked while reset is held so nothing leaks through the bypass.
  assign w_wr      = rst_n && bus.RegWrite && (bus.rd != '0);
  assign w_fwd1    = c_byp && w_wr && (bus.rd == bus.rs1);
  assign w_fwd2    = c_byp && w_wr && (bus.rd == bus.rs2);
  assign w_fwd_iss = c_byp && w_wr && (bus.rd == bus.issue_rd);

  assign bus.i1     = (bus.rs1 == '0) ? '0 : (w_fwd1 ? bus.rwdata : r_regs[bus.rs1]);
  assign bus.rdata2 = (bus.rs2 == '0) ? '0 : (w_fwd2 ? bus.rwdata : r_regs[bus.rs2]);

  assign w_busy1 = (bus.rs1 != '0) && r_pend[bus.rs1] && !w_fwd1;
  assign w_busy2 = (bus.rs2 != '0) && r_pend[bus.rs2] && !w_fwd2;
  assign w_waw   = bus.issue_en && (bus.issue_rd != '0) && r_pend[bus.issue_rd] && !w_fwd_iss;
  assign w_stall = w_busy1 || w_busy2 || w_waw;

  assign bus.rs1_busy = w_busy1;
  assign bus.rs2_busy = w_busy2;
  assign bus.stall    = w_stall;
  assign bus.pend_cnt = r_pend_cnt;

  assign w_set  = bus.issue_en && (bus.issue_rd != '0) && !w_stall;
  assign w_same = w_set && w_wr && (bus.rd == bus.issue_rd);
  // A set+clear on one register leaves it pending, so the clear must not count.
  assign w_inc  = w_set && !r_pend[bus.issue_rd];
  assign w_dec  = w_wr && r_pend[bus.rd] && !w_same;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[bus.rd] <= bus.rwdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      if (w_wr)  r_pend[bus.rd]       <= 1'b0;
      if (w_set) r_pend[bus.issue_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_cnt <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_pend_cnt <= r_pend_cnt + {{AW{1'b0}}, 1'b1};
        2'b01:   r_pend_cnt <= r_pend_cnt - {{AW{1'b0}}, 1'b1};
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end
endmodule

`default_nettype wire
